// File: rtl/rf_wb_arbiter.sv
// Register-file write-port controller: round-robin ALU/load writeback, zero-init of x1..x31,
// and a pending-write scoreboard that raises read-after-write hazards for decode.
module rf_wb_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_req_i,
   input  logic        alu_valid_i,
   input  logic [4:0]  alu_rd_i,
   input  logic [31:0] alu_data_i,
   output logic        alu_ready_o,
   input  logic        ld_valid_i,
   input  logic [4:0]  ld_rd_i,
   input  logic [31:0] ld_data_i,
   output logic        ld_ready_o,
   input  logic        iss_valid_i,
   input  logic [4:0]  iss_rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   output logic        hz_rs1_o,
   output logic        hz_rs2_o,
   output logic        we3_o,
   output logic [4:0]  ad3_o,
   output logic [31:0] wd3_o,
   output logic        init_done_o
);

   typedef enum logic {StClear, StRun} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        rr_q, rr_d;  // 1: load was granted last
   logic [31:0] busy_q, busy_d;
   logic        we3_q, we3_d;
   logic [4:0]  ad3_q, ad3_d;
   logic [31:0] wd3_q, wd3_d;

   logic        run;
   logic        alu_gnt, ld_gnt, gnt;
   logic [4:0]  gnt_rd;
   logic [31:0] gnt_data;

   assign run = (state_q == StRun);

   // A clear request steals the cycle, so nobody is granted while it is pending.
   always_comb begin
      alu_gnt = 1'b0;
      ld_gnt  = 1'b0;
      if (run && !clr_req_i) begin
         if (alu_valid_i && ld_valid_i) begin
            alu_gnt = rr_q;
            ld_gnt  = ~rr_q;
         end else begin
            alu_gnt = alu_valid_i;
            ld_gnt  = ld_valid_i;
         end
      end
      gnt      = alu_gnt | ld_gnt;
      gnt_rd   = ld_gnt ? ld_rd_i : alu_rd_i;
      gnt_data = ld_gnt ? ld_data_i : alu_data_i;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      busy_d  = busy_q;
      we3_d   = 1'b0;
      ad3_d   = ad3_q;
      wd3_d   = wd3_q;
      unique case (state_q)
         StClear: begin
            we3_d = 1'b1;
            ad3_d = cnt_q;
            wd3_d = '0;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = StRun;
         end
         StRun: begin
            if (clr_req_i) begin
               state_d = StClear;
               cnt_d   = 5'd1;
               busy_d  = '0;
            end else begin
               if (gnt) begin
                  we3_d          = (gnt_rd != 5'd0);
                  ad3_d          = gnt_rd;
                  wd3_d          = gnt_data;
                  rr_d           = ld_gnt;
                  busy_d[gnt_rd] = 1'b0;
               end
               // Issue after clear: a newer producer for the same rd stays outstanding.
               if (iss_valid_i && (iss_rd_i != 5'd0)) busy_d[iss_rd_i] = 1'b1;
            end
         end
      endcase
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StClear;
         cnt_q   <= 5'd1;
         rr_q    <= 1'b0;
         busy_q  <= '0;
         we3_q   <= 1'b0;
         ad3_q   <= '0;
         wd3_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         busy_q  <= busy_d;
         we3_q   <= we3_d;
         ad3_q   <= ad3_d;
         wd3_q   <= wd3_d;
      end
   end

   assign alu_ready_o = alu_gnt;
   assign ld_ready_o  = ld_gnt;
   assign hz_rs1_o    = ~run | busy_q[rs1_i];
   assign hz_rs2_o    = ~run | busy_q[rs2_i];
   assign we3_o       = we3_q;
   assign ad3_o       = ad3_q;
   assign wd3_o       = wd3_q;
   assign init_done_o = run;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural model of the write port and scoreboard.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr_req, alu_valid, ld_valid, iss_valid;
   logic [4:0]  alu_rd, ld_rd, iss_rd, rs1, rs2;
   logic [31:0] alu_data, ld_data;
   logic        alu_ready, ld_ready, hz_rs1, hz_rs2, we3, init_done;
   logic [4:0]  ad3;
   logic [31:0] wd3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_req_i  (clr_req),
      .alu_valid_i(alu_valid),
      .alu_rd_i   (alu_rd),
      .alu_data_i (alu_data),
      .alu_ready_o(alu_ready),
      .ld_valid_i (ld_valid),
      .ld_rd_i    (ld_rd),
      .ld_data_i  (ld_data),
      .ld_ready_o (ld_ready),
      .iss_valid_i(iss_valid),
      .iss_rd_i   (iss_rd),
      .rs1_i      (rs1),
      .rs2_i      (rs2),
      .hz_rs1_o   (hz_rs1),
      .hz_rs2_o   (hz_rs2),
      .we3_o      (we3),
      .ad3_o      (ad3),
      .wd3_o      (wd3),
      .init_done_o(init_done)
   );

   task automatic chk1(input string name, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %b, expected %b", name, $time, got, exp);
      end
   endtask

   task automatic chk5(input string name, input logic [4:0] got, input logic [4:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
      end
   endtask

   // Behavioural model: clearing flag with a next-address counter, a pending-write set,
   // who was served last, and the word currently on the port.
   bit        m_clearing;
   int        m_next_addr;
   bit [31:0] m_pending;
   bit        m_last_was_ld;
   bit        m_we;
   bit [4:0]  m_ad;
   bit [31:0] m_wd;

   // Returns {load granted, alu granted}.
   function automatic bit [1:0] who_wins();
      if (m_clearing || clr_req) return 2'b00;
      if (alu_valid && ld_valid) return m_last_was_ld ? 2'b01 : 2'b10;
      return {ld_valid, alu_valid};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_clearing    <= 1'b1;
         m_next_addr   <= 1;
         m_pending     <= '0;
         m_last_was_ld <= 1'b0;
         m_we          <= 1'b0;
         m_ad          <= '0;
         m_wd          <= '0;
      end else begin : upd
         bit [1:0]  w;
         bit [31:0] p;
         w = who_wins();
         p = m_pending;
         if (m_clearing) begin
            m_we        <= 1'b1;
            m_ad        <= 5'(m_next_addr);
            m_wd        <= '0;
            m_next_addr <= m_next_addr + 1;
            if (m_next_addr == 31) m_clearing <= 1'b0;
         end else if (clr_req) begin
            m_clearing  <= 1'b1;
            m_next_addr <= 1;
            p           = '0;
            m_we        <= 1'b0;
         end else begin
            if (w != 2'b00) begin
               m_we          <= w[1] ? (ld_rd != 0) : (alu_rd != 0);
               m_ad          <= w[1] ? ld_rd : alu_rd;
               m_wd          <= w[1] ? ld_data : alu_data;
               m_last_was_ld <= w[1];
               p[w[1] ? ld_rd : alu_rd] = 1'b0;
            end else begin
               m_we <= 1'b0;
            end
            if (iss_valid && iss_rd != 0) p[iss_rd] = 1'b1;
         end
         m_pending <= p;
      end
   end

   always @(negedge clk) begin : compare
      bit [1:0] w;
      w = who_wins();
      chk1("alu_ready", alu_ready, w[0]);
      chk1("ld_ready", ld_ready, w[1]);
      chk1("hz_rs1", hz_rs1, m_clearing || m_pending[rs1]);
      chk1("hz_rs2", hz_rs2, m_clearing || m_pending[rs2]);
      chk1("we3", we3, m_we);
      chk5("ad3", ad3, m_ad);
      chk32("wd3", wd3, m_wd);
      chk1("init_done", init_done, !m_clearing);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin : main
      bit alu_acc, ld_acc;
      clr_req = 0; alu_valid = 0; ld_valid = 0; iss_valid = 0;
      alu_rd = 0; ld_rd = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
      alu_data = 0; ld_data = 0;
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_we3", we3, 1'b0);
      chk5("rst_ad3", ad3, 5'd0);
      chk1("rst_init_done", init_done, 1'b0);
      chk1("rst_hz_rs1", hz_rs1, 1'b1);
      @(negedge clk) rst_n = 1'b1;

      // Zero-init sequence
      for (int k = 1; k <= 31; k++) begin
         step();
         chk1("init_we3", we3, 1'b1);
         chk5("init_ad3", ad3, 5'(k));
         chk32("init_wd3", wd3, 32'h0);
         chk1("init_done_seq", init_done, k == 31);
         if (k < 31) chk1("init_hz", hz_rs1, 1'b1);
      end

      // Single ALU write
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      #1 chk1("alu_single_ready", alu_ready, 1'b1);
      step();
      alu_valid = 0;
      chk1("alu_single_we3", we3, 1'b1);
      chk5("alu_single_ad3", ad3, 5'd5);
      chk32("alu_single_wd3", wd3, 32'hDEADBEEF);
      step();
      chk1("alu_single_idle", we3, 1'b0);

      // Contention: load wins first, then strict alternation
      alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
      ld_valid = 1; ld_rd = 4; ld_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk1("cont_ld_ready", ld_ready, i % 2 == 0);
         chk1("cont_alu_ready", alu_ready, i % 2 == 1);
         step();
         chk5("cont_ad3", ad3, (i % 2 == 0) ? 5'd4 : 5'd3);
         chk32("cont_wd3", wd3, (i % 2 == 0) ? 32'h22 : 32'h11);
      end
      alu_valid = 0; ld_valid = 0;

      // Write to x0 handshakes but never strobes the port
      ld_valid = 1; ld_rd = 0; ld_data = 32'hFFFFFFFF;
      #1 chk1("x0_ready", ld_ready, 1'b1);
      step();
      ld_valid = 0;
      chk1("x0_we3", we3, 1'b0);

      // Scoreboard set, hold, clear
      iss_valid = 1; iss_rd = 7; rs1 = 7;
      step();
      iss_valid = 0;
      chk1("sb_set", hz_rs1, 1'b1);
      step();
      alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
      #1;
      chk1("sb_accept_ready", alu_ready, 1'b1);
      chk1("sb_accept_cycle_hz", hz_rs1, 1'b1);
      step();
      alu_valid = 0;
      chk1("sb_cleared", hz_rs1, 1'b0);
      chk5("sb_port_ad3", ad3, 5'd7);

      // Set and clear of the same rd on one edge: set wins
      iss_valid = 1; iss_rd = 7;
      step();
      alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
      step();
      alu_valid = 0; iss_valid = 0;
      chk1("sb_set_wins", hz_rs1, 1'b1);
      chk1("sb_set_wins_we3", we3, 1'b1);
      alu_valid = 1;
      step();
      alu_valid = 0;
      chk1("sb_final_clear", hz_rs1, 1'b0);

      // Mid-run clear with a held ALU request
      iss_valid = 1; iss_rd = 9; rs2 = 9;
      step();
      iss_valid = 0;
      chk1("mc_busy9", hz_rs2, 1'b1);
      alu_valid = 1; alu_rd = 10; alu_data = 32'hA5A5_0010; clr_req = 1;
      #1 chk1("mc_ready_blocked", alu_ready, 1'b0);
      step();
      clr_req = 0;
      chk1("mc_init_done", init_done, 1'b0);
      chk1("mc_we3", we3, 1'b0);
      for (int k = 1; k <= 31; k++) begin
         chk1("mc_ready_in_clear", alu_ready, 1'b0);
         step();
         chk5("mc_ad3", ad3, 5'(k));
      end
      chk1("mc_run_ready", alu_ready, 1'b1);
      chk1("mc_busy_gone", hz_rs2, 1'b0);
      step();
      alu_valid = 0;
      chk5("mc_grant_ad3", ad3, 5'd10);
      chk32("mc_grant_wd3", wd3, 32'hA5A5_0010);

      // Randomized traffic; requesters hold until accepted
      alu_acc = 0; ld_acc = 0;
      for (int it = 0; it < 3000; it++) begin
         if (!alu_valid || alu_acc) begin
            alu_valid = 1'($urandom_range(0, 1));
            alu_rd = 5'($urandom_range(0, 7));
            alu_data = $urandom;
         end
         if (!ld_valid || ld_acc) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_rd = 5'($urandom_range(0, 7));
            ld_data = $urandom;
         end
         iss_valid = ($urandom_range(0, 2) == 0);
         iss_rd = 5'($urandom_range(0, 7));
         rs1 = 5'($urandom_range(0, 7));
         rs2 = 5'($urandom_range(0, 7));
         clr_req = ($urandom_range(0, 199) == 0);
         if (it == 1500 || it == 1510) begin
            rst_n = 0;
            #2 rst_n = 1;
         end
         @(negedge clk);
         alu_acc = alu_ready;
         ld_acc = ld_ready;
         step();
      end
      alu_valid = 0; ld_valid = 0; iss_valid = 0; clr_req = 0;
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port controller for the 32 x 32-bit register file in the reduced RISC-V core. It shares the file's single write port (WE3/AD3/WD3) between two writeback requesters, the ALU and the load unit, using round-robin arbitration and a registered one-cycle output. It also zero-initialises x1..x31 after reset or on request. A pending-write scoreboard gives the decode stage read-after-write hazard flags for rs1/rs2.

## Interface
- No parameters: XLEN = 32, 32 registers and 5-bit addresses are fixed.
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr_req  in  1  one-cycle pulse: re-run the zero-init sequence
- alu_valid / alu_rd / alu_data  in  1/5/32  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle (valid && ready)
- ld_valid / ld_rd / ld_data  in  1/5/32  load writeback request
- ld_ready  out  1  load request accepted this cycle
- iss_valid / iss_rd  in  1/5  instruction issued that will write rd; reserve it
- rs1 / rs2  in  5/5  decode source addresses
- hz_rs1 / hz_rs2  out  1/1  source has a pending write, or init is in progress
- we3 / ad3 / wd3  out  1/5/32  registered write port to the register file
- init_done  out  1  high in RUN

## Operation
- State machine has two states: CLEAR and RUN. Async reset enters CLEAR with cnt = 1.
- **CLEAR**
  - Each edge loads the output register with we3=1, ad3=cnt, wd3=0, then increments cnt.
  - On the edge that loads ad3=31: go to RUN and set init_done=1.
  - alu_ready = ld_ready = 0.
  - iss_valid is ignored.
  - hz_rs1 = hz_rs2 = 1.
  - clr_req is ignored.
- **RUN, arbitration**
  - rr pointer records the last-granted requester. Reset value is ALU, so load wins the first contention.
  - Only one valid: that requester is granted.
  - Both valid: the requester not named by rr is granted. rr updates on every grant.
  - Ready is asserted only to the granted requester. Requesters hold valid/rd/data until ready.
- **Output register**
  - In CLEAR: the clear write.
  - Else on a grant: we3 = (rd != 0), ad3 = rd, wd3 = data.
  - Otherwise: we3 = 0. ad3 and wd3 hold their previous values.
  - A grant with rd = 0 still completes the handshake and clears nothing.
- **Scoreboard**
  - busy[31:1] is reset to 0. busy[0] is constantly 0.
  - An accepted grant to rd clears busy[rd].
  - iss_valid with iss_rd != 0 sets busy[iss_rd].
  - Set and clear of the same rd on the same edge: set wins (a newer producer is outstanding).
  - hz_rsN = busy[rsN]; combinational, RUN only.
- **clr_req in RUN**
  - Forces both readies to 0 that cycle.
  - Next edge: CLEAR, cnt=1, init_done=0, busy=0, we3=0.
  - A write already registered before that edge has been presented and completes normally.

## Timing
- Reset values: we3=0, ad3=0, wd3=0, init_done=0, alu_ready=0, ld_ready=0, hz_rs1=hz_rs2=1, busy=0, rr=ALU.
- Let E1 be the first rising edge with rst_n high.
  - Clear writes ad3=1..31 are presented after E1..E31.
  - init_done is high from E31.
  - The first grant can occur in the cycle after E31. Its write is presented after E32.
- Writeback latency: request accepted in cycle N gives we3/ad3/wd3 in cycle N+1. The register file commits at the end of N+1.
- Throughput: one accepted write per cycle. Under continuous contention, grants alternate strictly.
- Scoreboard clear takes effect at the accept edge. hz for that rd drops in cycle N+1, the same cycle the write is on the port.
- Reset asserted mid-operation (any state): all state returns immediately to reset values. A partial write is never presented.

## Test plan
- **Reset init:** release rst_n, no requests -> we3=1 with ad3=1..31 and wd3=0 on 31 consecutive cycles; init_done=1 from ad3=31; hz outputs 1 until then.
- **Single ALU write:** in RUN, alu_valid, rd=5, data=0xDEADBEEF -> alu_ready same cycle; next cycle we3=1, ad3=5, wd3=0xDEADBEEF; following cycle we3=0.
- **Contention:** ALU (rd=3, 0x11) and load (rd=4, 0x22) both valid for 4 cycles after init -> grants ld, alu, ld, alu; port sequence ad3 = 4, 3, 4, 3.
- **x0 write:** ld_valid, rd=0, data=0xFFFFFFFF -> ld_ready=1; we3 stays 0.
- **Scoreboard:**
  - iss_valid rd=7, then rs1=7 -> hz_rs1=1 until the ALU write to 7 is accepted; 0 from the next cycle.
  - iss_rd=7 on the same edge as an accept to 7 -> hz_rs1 stays 1.
- **Mid-run clear:** with busy[9]=1 and alu_valid held, pulse clr_req -> alu_ready=0 that cycle, busy cleared, init_done=0; the 31-write clear sequence repeats; the held ALU request is granted in the first RUN cycle.
